// File: rtl/pico_seq_pkg.sv
// Shared types for the picoMips sequencer: opcodes, FSM states, instruction
// field positions and the instruction-to-strobe decoder.
package pico_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDSW = 4'h2,
    OP_LDR  = 4'h3,
    OP_ADDI = 4'h4,
    OP_ADDR = 4'h5,
    OP_MULI = 4'h6,
    OP_MACR = 4'h7,
    OP_STR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_WTP  = 4'hA,
    OP_BZ   = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_PRESS,
    S_WAIT_REL,
    S_HALT
  } state_t;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RA_MSB  = 11;
  localparam int unsigned RA_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic reg_we;
    logic we;
    logic sel_imm;
    logic sel_sw;
    logic sel_reg;
    logic use_mul;
    logic use_acc;
  } strobes_t;

  // Opcodes 0xC-0xE fall through to the all-zero default, i.e. NOP.
  function automatic strobes_t decode(input opcode_t op);
    strobes_t s;
    s = '0;
    case (op)
      OP_LDI:  begin s.we = 1'b1; s.sel_imm = 1'b1; end
      OP_LDSW: begin s.we = 1'b1; s.sel_sw  = 1'b1; end
      OP_LDR:  begin s.we = 1'b1; s.sel_reg = 1'b1; end
      OP_ADDI: begin s.we = 1'b1; s.use_acc = 1'b1; s.sel_imm = 1'b1; end
      OP_ADDR: begin s.we = 1'b1; s.use_acc = 1'b1; s.sel_reg = 1'b1; end
      OP_MULI: begin s.we = 1'b1; s.use_acc = 1'b1; s.use_mul = 1'b1; end
      OP_MACR: begin
        s.we      = 1'b1;
        s.use_acc = 1'b1;
        s.sel_reg = 1'b1;
        s.use_mul = 1'b1;
      end
      OP_STR:  s.reg_we = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pico_seq_if.sv
// Sequencer-to-datapath bus: ROM fetch, ALU controls and register-file controls.
interface pico_seq_if #(
  parameter int unsigned PC_W = 8
);
  logic [15:0]     Instr;
  logic [PC_W-1:0] PC;
  logic [7:0]      ACC;
  logic [7:0]      Imm;
  logic [3:0]      RegAddr;
  logic            RegWE;
  logic            WE;
  logic            SelImm;
  logic            SelSW;
  logic            SelRegData;
  logic            UseMul;
  logic            UseACC;

  modport master (
    input  Instr, ACC,
    output PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelRegData, UseMul, UseACC
  );

  modport slave (
    output Instr, ACC,
    input  PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelRegData, UseMul, UseACC
  );
endinterface

// File: rtl/pico_seq_btn_sync.sv
// N-stage synchroniser for the asynchronous push-button; all stages clear on reset.
module btn_sync #(
  parameter int unsigned N = 2
) (
  input  logic Clock,
  input  logic nReset,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) ff <= '0;
    else         ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];
endmodule

// File: rtl/pico_seq.sv
// picoMips instruction sequencer: owns the PC, decodes ROM words into datapath
// strobes and handles the button-wait handshake and halt.
module pico_seq
  import pico_seq_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Btn,
  output logic        Halted,
  pico_seq_if.master  bus
);
  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next, pc_inc, imm_pc;
  logic            btn_s;
  opcode_t         op;
  strobes_t        stb;

  btn_sync #(.N(SYNC_STAGES)) u_btn_sync (
    .Clock  (Clock),
    .nReset (nReset),
    .d      (Btn),
    .q      (btn_s)
  );

  assign op     = opcode_t'(bus.Instr[OP_MSB:OP_LSB]);
  assign pc_inc = pc + PC_W'(1);
  // Immediate truncates or zero-extends to the PC width.
  assign imm_pc = PC_W'(bus.Instr[IMM_MSB:IMM_LSB]);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_RUN;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      S_RUN: begin
        case (op)
          OP_JMP:  pc_next = imm_pc;
          OP_WTP:  state_next = S_WAIT_PRESS;
          OP_BZ:   pc_next = (bus.ACC == '0) ? imm_pc : pc_inc;
          OP_HALT: state_next = S_HALT;
          default: pc_next = pc_inc;
        endcase
      end
      S_WAIT_PRESS: begin
        if (btn_s) state_next = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!btn_s) begin
          state_next = S_RUN;
          pc_next    = pc_inc;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  always_comb begin
    stb = '0;
    if (state == S_RUN) stb = decode(op);
  end

  assign bus.PC         = pc;
  assign bus.Imm        = bus.Instr[IMM_MSB:IMM_LSB];
  assign bus.RegAddr    = bus.Instr[RA_MSB:RA_LSB];
  assign bus.RegWE      = stb.reg_we;
  assign bus.WE         = stb.we;
  assign bus.SelImm     = stb.sel_imm;
  assign bus.SelSW      = stb.sel_sw;
  assign bus.SelRegData = stb.sel_reg;
  assign bus.UseMul     = stb.use_mul;
  assign bus.UseACC     = stb.use_acc;
  assign Halted         = (state == S_HALT);
endmodule
